core_sequencer: RTL and testbench

- Multi-cycle control FSM for the scalar RV32 core. It drives the shared `state` bus (FETCH=0, DECODE=1, EXEC=2, MEM=3, WRITE=4) that the decode, ALU, memory and writeback stages qualify on.
- It owns the handshakes with instruction memory, data memory and the UART rx/tx FIFOs, plus halt detection and performance counters.

---
 rtl/core_sequencer.sv | 154 +++++++++++++++
 tb/tb_core_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for the scalar RV32 core.
// Owns imem/dmem/UART handshakes, halt detection and perf counters.
module core_sequencer #(
  parameter logic [31:0] HALT_INSTR = 32'h0000006F,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      instr_raw,
  input  logic             instr_valid,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             data_in,
  input  logic             data_out,
  input  logic             mem_ready,
  input  logic             rx_valid,
  input  logic             tx_ready,
  output logic [2:0]       state,
  output logic             fetch_req,
  output logic             mem_req,
  output logic             rx_pop,
  output logic             tx_push,
  output logic             pc_we,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WRITE  = 3'd4,
    S_HALT   = 3'd5,
    S_IDLE   = 3'd7
  } st_t;

  typedef enum logic [1:0] {
    K_NONE = 2'd0,
    K_LDST = 2'd1,
    K_IN   = 2'd2,
    K_OUT  = 2'd3
  } kind_t;

  localparam logic [CNT_W-1:0] ONE = 1;

  st_t   st;
  kind_t kind;
  logic  mem_done;
  logic  stall_max;

  assign state     = st;
  assign stall_max = &stall_count;

  // completion condition of the access kind latched in EXEC
  always_comb begin
    mem_done = 1'b0;
    case (kind)
      K_LDST:  mem_done = mem_ready;
      K_IN:    mem_done = rx_valid;
      K_OUT:   mem_done = tx_ready;
      default: mem_done = 1'b1;
    endcase
  end

  // state register, registered handshake outputs and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= S_IDLE;
      kind        <= K_NONE;
      fetch_req   <= 1'b0;
      mem_req     <= 1'b0;
      rx_pop      <= 1'b0;
      tx_push     <= 1'b0;
      pc_we       <= 1'b0;
      halted      <= 1'b0;
      instr_count <= '0;
      stall_count <= '0;
    end else begin
      mem_req <= 1'b0;
      rx_pop  <= 1'b0;
      tx_push <= 1'b0;
      pc_we   <= 1'b0;
      case (st)
        S_IDLE: begin
          if (start) begin
            st        <= S_FETCH;
            fetch_req <= 1'b1;
          end
        end
        S_FETCH: begin
          if (instr_valid) begin
            st        <= S_DECODE;
            fetch_req <= 1'b0;
          end else if (!stall_max) begin
            stall_count <= stall_count + ONE;
          end
        end
        S_DECODE: begin
          if (instr_raw == HALT_INSTR) begin
            st     <= S_HALT;
            halted <= 1'b1;
          end else begin
            st <= S_EXEC;
          end
        end
        S_EXEC: begin
          // data_in/data_out vanish after EXEC, so the kind is latched here
          if (mem_read || mem_write) begin
            kind    <= K_LDST;
            st      <= S_MEM;
            mem_req <= 1'b1;
          end else if (data_in) begin
            kind <= K_IN;
            st   <= S_MEM;
          end else if (data_out) begin
            kind <= K_OUT;
            st   <= S_MEM;
          end else begin
            kind  <= K_NONE;
            st    <= S_WRITE;
            pc_we <= 1'b1;
          end
        end
        S_MEM: begin
          if (mem_done) begin
            st      <= S_WRITE;
            pc_we   <= 1'b1;
            rx_pop  <= (kind == K_IN);
            tx_push <= (kind == K_OUT);
          end else if (!stall_max) begin
            stall_count <= stall_count + ONE;
          end
        end
        S_WRITE: begin
          instr_count <= instr_count + ONE;
          st          <= S_FETCH;
          fetch_req   <= 1'b1;
        end
        S_HALT: begin
          st <= S_HALT;
        end
        default: begin
          st        <= S_IDLE;
          fetch_req <= 1'b0;
          halted    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed stimulus with a pc_we-driven scoreboard.
// Built with CNT_W=4 so counter wrap/saturation are reachable.
module tb_core_sequencer;

  localparam int CW = 4;
  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] LW   = 32'h0000A083;
  localparam logic [31:0] SW   = 32'h00112023;
  localparam logic [31:0] IOOP = 32'h00000080;
  localparam logic [31:0] HALT = 32'h0000006F;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   instr_raw;
  logic          instr_valid;
  logic          mem_read;
  logic          mem_write;
  logic          data_in;
  logic          data_out;
  logic          mem_ready;
  logic          rx_valid;
  logic          tx_ready;
  logic [2:0]    state;
  logic          fetch_req;
  logic          mem_req;
  logic          rx_pop;
  logic          tx_push;
  logic          pc_we;
  logic          halted;
  logic [CW-1:0] instr_count;
  logic [CW-1:0] stall_count;

  core_sequencer #(
    .HALT_INSTR(HALT),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .instr_raw(instr_raw),
    .instr_valid(instr_valid),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .data_in(data_in),
    .data_out(data_out),
    .mem_ready(mem_ready),
    .rx_valid(rx_valid),
    .tx_ready(tx_ready),
    .state(state),
    .fetch_req(fetch_req),
    .mem_req(mem_req),
    .rx_pop(rx_pop),
    .tx_push(tx_push),
    .pc_we(pc_we),
    .halted(halted),
    .instr_count(instr_count),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rx;
    logic          tx;
    logic [CW-1:0] ic;
    logic [CW-1:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_mreq = 0;
  int   n_rx   = 0;
  int   n_tx   = 0;
  int   n_pw   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic rx, input logic tx,
                          input int ic, input int sc);
    exp_t e;
    e.rx = rx;
    e.tx = tx;
    e.ic = CW'(ic);
    e.sc = CW'(sc);
    exp_q.push_back(e);
  endtask

  task automatic clear_in();
    start       = 1'b0;
    instr_raw   = 32'h0;
    instr_valid = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    data_in     = 1'b0;
    data_out    = 1'b0;
    mem_ready   = 1'b0;
    rx_valid    = 1'b0;
    tx_ready    = 1'b0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // monitor: counts pulses and checks each retirement against the queue
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req) n_mreq++;
      if (rx_pop)  n_rx++;
      if (tx_push) n_tx++;
      if (pc_we) begin
        n_pw++;
        chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wb_rx_pop", 32'(rx_pop), 32'(e.rx));
          chk("wb_tx_push", 32'(tx_push), 32'(e.tx));
          chk("wb_instr_count", 32'(instr_count), 32'(e.ic));
          chk("wb_stall_count", 32'(stall_count), 32'(e.sc));
        end
      end
    end
  end

  // k: 0 load (with data_in also set), 1 data_in (with data_out set), 2 data_out
  task automatic mem_instr(input int k, input int waits);
    int mr0, rp0, tp0, pw0;
    do_reset();
    mr0 = n_mreq; rp0 = n_rx; tp0 = n_tx; pw0 = n_pw;
    push_exp(k == 1, k == 2, 0, waits);
    instr_raw   = (k == 0) ? LW : IOOP;
    mem_read    = (k == 0);
    data_in     = (k == 0) || (k == 1);
    data_out    = (k == 1) || (k == 2);
    mem_ready   = (k != 0);
    rx_valid    = (k != 1);
    tx_ready    = (k != 2);
    start       = 1'b1;
    instr_valid = 1'b1;
    step(); chk("m_fetch", 32'(state), 32'd0);
    step(); chk("m_decode", 32'(state), 32'd1);
    step(); chk("m_exec", 32'(state), 32'd2);
    step(); chk("m_mem0", 32'(state), 32'd3);
    chk("m_mem_req0", 32'(mem_req), 32'(k == 0));
    for (int w = 1; w <= waits; w++) begin
      step();
      chk("m_memw", 32'(state), 32'd3);
      chk("m_mem_req_w", 32'(mem_req), 32'd0);
    end
    case (k)
      0:       mem_ready = 1'b1;
      1:       rx_valid  = 1'b1;
      default: tx_ready  = 1'b1;
    endcase
    instr_valid = 1'b0;
    step(); chk("m_write", 32'(state), 32'd4);
    clear_in();
    step(); chk("m_refetch", 32'(state), 32'd0);
    chk("m_icnt", 32'(instr_count), 32'd1);
    chk("m_scnt", 32'(stall_count), 32'(waits));
    chk("m_nmreq", 32'(n_mreq - mr0), 32'(k == 0));
    chk("m_nrx", 32'(n_rx - rp0), 32'(k == 1));
    chk("m_ntx", 32'(n_tx - tp0), 32'(k == 2));
    chk("m_npw", 32'(n_pw - pw0), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_st[5];
    int mr0, rp0, tp0, pw0;
    exp_st = '{0, 1, 2, 4, 0};

    // reset state
    do_reset();
    chk("rst_state", 32'(state), 32'd7);
    chk("rst_fetch_req", 32'(fetch_req), 32'd0);
    chk("rst_pulses", 32'({mem_req, rx_pop, tx_push, pc_we}), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_icnt", 32'(instr_count), 32'd0);
    chk("rst_scnt", 32'(stall_count), 32'd0);

    // plain ALU instruction
    pw0 = n_pw;
    push_exp(1'b0, 1'b0, 0, 0);
    instr_raw   = ADDI;
    start       = 1'b1;
    instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("addi_state", 32'(state), 32'(exp_st[i]));
      if (i == 0) chk("addi_freq_on", 32'(fetch_req), 32'd1);
      if (i == 1) chk("addi_freq_off", 32'(fetch_req), 32'd0);
    end
    clear_in();
    chk("addi_icnt", 32'(instr_count), 32'd1);
    chk("addi_scnt", 32'(stall_count), 32'd0);
    chk("addi_npw", 32'(n_pw - pw0), 32'd1);

    // memory and I/O instructions
    mem_instr(0, 3);
    mem_instr(0, 0);
    mem_instr(1, 5);
    mem_instr(2, 5);
    mem_instr(2, 0);

    // halt after one retired instruction
    do_reset();
    push_exp(1'b0, 1'b0, 0, 0);
    instr_raw   = ADDI;
    start       = 1'b1;
    instr_valid = 1'b1;
    step(); step(); step(); step();
    chk("h_write", 32'(state), 32'd4);
    instr_raw = HALT;
    step(); step();
    chk("h_decode", 32'(state), 32'd1);
    step();
    chk("h_state", 32'(state), 32'd5);
    chk("h_halted", 32'(halted), 32'd1);
    mr0 = n_mreq; rp0 = n_rx; tp0 = n_tx; pw0 = n_pw;
    mem_ready = 1'b1;
    rx_valid  = 1'b1;
    tx_ready  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      start       = i[0];
      instr_valid = ~i[0];
      step();
      chk("h_stay", 32'(state), 32'd5);
    end
    chk("h_halted2", 32'(halted), 32'd1);
    chk("h_icnt", 32'(instr_count), 32'd1);
    chk("h_scnt", 32'(stall_count), 32'd0);
    chk("h_freq", 32'(fetch_req), 32'd0);
    chk("h_pulses", 32'((n_mreq - mr0) + (n_rx - rp0) + (n_tx - tp0)), 32'd0);
    chk("h_npw", 32'(n_pw - pw0), 32'd0);
    do_reset();
    chk("h_rst_state", 32'(state), 32'd7);
    chk("h_rst_halted", 32'(halted), 32'd0);
    chk("h_rst_icnt", 32'(instr_count), 32'd0);

    // reset during a store's MEM wait
    do_reset();
    instr_raw   = SW;
    mem_write   = 1'b1;
    start       = 1'b1;
    instr_valid = 1'b1;
    step(); step(); step(); step();
    chk("r_mem", 32'(state), 32'd3);
    chk("r_mem_req", 32'(mem_req), 32'd1);
    step();
    chk("r_mem_req_off", 32'(mem_req), 32'd0);
    chk("r_scnt", 32'(stall_count), 32'd1);
    rst = 1'b1;
    step();
    chk("r_state", 32'(state), 32'd7);
    chk("r_pulses", 32'({mem_req, pc_we, fetch_req}), 32'd0);
    chk("r_icnt", 32'(instr_count), 32'd0);
    chk("r_scnt0", 32'(stall_count), 32'd0);
    mr0 = n_mreq; pw0 = n_pw;
    clear_in();
    rst       = 1'b0;
    mem_ready = 1'b1;
    step(); step();
    chk("r_idle", 32'(state), 32'd7);
    chk("r_nmreq", 32'(n_mreq - mr0), 32'd0);
    chk("r_npw", 32'(n_pw - pw0), 32'd0);

    // instr_count wraps after 16 retirements
    do_reset();
    for (int i = 0; i < 16; i++) push_exp(1'b0, 1'b0, i, 0);
    instr_raw   = ADDI;
    start       = 1'b1;
    instr_valid = 1'b1;
    step();
    for (int i = 0; i < 60; i++) step();
    chk("w_fetch", 32'(state), 32'd0);
    chk("w_icnt15", 32'(instr_count), 32'd15);
    for (int i = 0; i < 4; i++) step();
    instr_valid = 1'b0;
    chk("w_icnt0", 32'(instr_count), 32'd0);

    // stall_count saturates
    do_reset();
    start = 1'b1;
    step();
    for (int i = 0; i < 15; i++) step();
    chk("s_sat", 32'(stall_count), 32'd15);
    for (int i = 0; i < 5; i++) step();
    chk("s_hold", 32'(stall_count), 32'd15);
    chk("s_freq", 32'(fetch_req), 32'd1);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
